// File: rtl/buffer_memory_pkg.sv
// Shared constants and helpers for the buffer memory: read-during-write policy
// codes, controller state encodings and the byte-lane count helper.
package buffer_memory_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int BYTES(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/buffer_memory_core.sv
// Raw simple-dual-port array: byte-masked write port and a read-first
// registered read port, shaped so a vendor RAM macro can replace it directly.
module buffer_memory_core
  import buffer_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [BYTES(DATA_W)-1:0]   be,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = BYTES(DATA_W);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Non-blocking read and write in one block gives old-data on a collision.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/buffer_memory_dp.sv
// Payload buffer between packet parser and checksum/transmit logic: clear
// sequencer, write mux, read-during-write bypass and 1- or 2-cycle read path.
module buffer_memory_dp
  import buffer_memory_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addr_wr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     wr_en,
  input  logic [BYTES(DATA_W)-1:0] byte_en,
  input  logic [ADDR_W-1:0]        addr_rd,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     init_busy
);

  localparam int                NB          = BYTES(DATA_W);
  localparam logic              CLEAR_EN    = (CLEAR_ON_RESET != 0);
  localparam state_t            RESET_STATE = CLEAR_EN ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              init_busy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RESET_STATE;
      clr_cnt_reg   <= '0;
      init_busy_reg <= CLEAR_EN;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg     <= ST_RUN;
            init_busy_reg <= 1'b0;
          end
        end
        default: begin
          init_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = init_busy_reg;

  logic clearing;
  logic wr_accept;
  logic rd_accept;

  assign clearing  = (state_reg == ST_CLEAR);
  assign wr_accept = !clearing && wr_en;
  assign rd_accept = !clearing && rd_en;

  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic [NB-1:0]     core_be;
  logic [DATA_W-1:0] core_rdata;

  always_comb begin
    core_we    = wr_accept;
    core_waddr = addr_wr;
    core_wdata = data_in;
    core_be    = byte_en;
    if (clearing) begin
      core_we    = 1'b1;
      core_waddr = clr_cnt_reg;
      core_wdata = '0;
      core_be    = '1;
    end
  end

  buffer_memory_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .be    (core_be),
    .re    (rd_accept),
    .raddr (addr_rd),
    .rdata (core_rdata)
  );

  // The core always returns old data; new-data mode overlays the colliding
  // write's enabled bytes one cycle later, captured alongside the read.
  logic rdw_hit;
  assign rdw_hit = (RDW_MODE == RDW_NEW) && wr_accept && (addr_wr == addr_rd);

  logic              hit_reg;
  logic [DATA_W-1:0] byp_data_reg;
  logic [NB-1:0]     byp_be_reg;

  always_ff @(posedge clk) begin
    if (rd_accept) begin
      hit_reg      <= rdw_hit;
      byp_data_reg <= data_in;
      byp_be_reg   <= byte_en;
    end
  end

  logic [DATA_W-1:0] stage1_data;

  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign stage1_data[8*gi +: 8] = (hit_reg && byp_be_reg[gi]) ?
                                    byp_data_reg[8*gi +: 8] : core_rdata[8*gi +: 8];
  end

  logic rd_pipe_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe_reg <= 1'b0;
    end else begin
      rd_pipe_reg <= rd_accept;
    end
  end

  if ((RD_LATENCY != 1 && RD_LATENCY != 2) || (DATA_W % 8 != 0)) begin : g_bad_param
    $error("buffer_memory_dp: RD_LATENCY must be 1 or 2 and DATA_W a multiple of 8");
    assign data_out = '0;
    assign rd_valid = 1'b0;
  end else if (RD_LATENCY == 1) begin : g_lat1
    // The core read register has no reset, so mask it until a read lands.
    logic have_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        have_reg <= 1'b0;
      end else if (rd_accept) begin
        have_reg <= 1'b1;
      end
    end

    assign data_out = have_reg ? stage1_data : '0;
    assign rd_valid = rd_pipe_reg;
  end else begin : g_lat2
    logic              valid2_reg;
    logic [DATA_W-1:0] out_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid2_reg <= 1'b0;
        out_reg    <= '0;
      end else begin
        valid2_reg <= rd_pipe_reg;
        if (rd_pipe_reg) begin
          out_reg <= stage1_data;
        end
      end
    end

    assign data_out = out_reg;
    assign rd_valid = valid2_reg;
  end

endmodule

// File: tb/tb_buffer_memory_dp.sv
// Drives two buffer memories in lockstep (latency 1 / old-data and latency 2 /
// new-data) against a word-level model plus directed literal expectations.
module tb_buffer_memory_dp;
  import buffer_memory_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr_wr = '0;
  logic [AW-1:0] addr_rd = '0;
  logic [DW-1:0] data_in = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [NB-1:0] byte_en = '0;

  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b, busy_a, busy_b;

  always #5 clk = ~clk;

  buffer_memory_dp #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .reset(rst), .addr_wr(addr_wr), .data_in(data_in), .wr_en(wr_en),
    .byte_en(byte_en), .addr_rd(addr_rd), .rd_en(rd_en), .data_out(data_a),
    .rd_valid(valid_a), .init_busy(busy_a)
  );

  buffer_memory_dp #(
    .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(2), .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .reset(rst), .addr_wr(addr_wr), .data_in(data_in), .wr_en(wr_en),
    .byte_en(byte_en), .addr_rd(addr_rd), .rd_en(rd_en), .data_out(data_b),
    .rd_valid(valid_b), .init_busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: memory contents, remaining clear writes, and the read
  // results each configuration must present after the current edge.
  logic [DW-1:0] mdl [DEPTH];
  int            clear_left  = 0;
  logic [DW-1:0] exp_data_a  = '0;
  logic [DW-1:0] exp_data_b  = '0;
  logic          exp_valid_a = 1'b0;
  logic          exp_valid_b = 1'b0;
  logic          pend_v      = 1'b0;
  logic [DW-1:0] pend_d      = '0;

  always @(posedge clk) begin
    logic [DW-1:0] old_word;
    if (rst) begin
      clear_left  = DEPTH;
      exp_data_a  = '0;
      exp_data_b  = '0;
      exp_valid_a = 1'b0;
      exp_valid_b = 1'b0;
      pend_v      = 1'b0;
    end else begin
      exp_valid_a = 1'b0;
      exp_valid_b = pend_v;
      if (pend_v) exp_data_b = pend_d;
      pend_v = 1'b0;
      if (clear_left > 0) begin
        mdl[DEPTH - clear_left] = '0;
        clear_left--;
      end else begin
        old_word = mdl[addr_rd];
        if (wr_en) begin
          for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) mdl[addr_wr][8*i +: 8] = data_in[8*i +: 8];
          end
        end
        if (rd_en) begin
          exp_valid_a = 1'b1;
          exp_data_a  = old_word;
          pend_v      = 1'b1;
          pend_d      = mdl[addr_rd];
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_data",  data_a,  rst ? 32'h0 : exp_data_a);
      chk("a_valid", {31'h0, valid_a}, rst ? 32'h0 : {31'h0, exp_valid_a});
      chk("a_busy",  {31'h0, busy_a},  (rst || clear_left > 0) ? 32'h1 : 32'h0);
      chk("b_data",  data_b,  rst ? 32'h0 : exp_data_b);
      chk("b_valid", {31'h0, valid_b}, rst ? 32'h0 : {31'h0, exp_valid_b});
      chk("b_busy",  {31'h0, busy_b},  (rst || clear_left > 0) ? 32'h1 : 32'h0);
    end
  end

  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra);
    wr_en   = we;
    addr_wr = wa;
    data_in = wd;
    byte_en = be;
    rd_en   = re;
    addr_rd = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    cyc(1'b1, a, d, be, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cyc(1'b0, '0, '0, '0, 1'b1, a);
  endtask

  // Bounded: an init_busy that never falls ends with n = 40.
  task automatic count_clear(input logic re, output int n, output int seen);
    n    = 0;
    seen = 0;
    while (busy_a && n < 40) begin
      cyc(1'b0, '0, '0, '0, re, n[AW-1:0]);
      n++;
      if (valid_a || valid_b) seen++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;

    rst = 1'b1;
    idle();
    idle();
    cmp_en = 1'b1;
    chk("rst_busy",  {31'h0, busy_a},  32'h1);
    chk("rst_valid", {31'h0, valid_b}, 32'h0);
    chk("rst_data",  data_b, 32'h0);

    rst = 1'b0;
    count_clear(1'b0, n, seen);
    chk("clear1_cycles", n, 16);

    for (int i = 0; i < DEPTH; i++) wr(i[AW-1:0], 32'hFFFF_FFFF, 4'hF);
    rd(4'd9);
    chk("preload_read", data_a, 32'hFFFF_FFFF);

    // dut_b's read above is still in flight: reset must drop it.
    rst = 1'b1;
    chk("inflight_dropped", {31'h0, valid_b}, 32'h0);
    idle();
    idle();
    rst = 1'b0;
    count_clear(1'b1, n, seen);
    chk("clear2_cycles", n, 16);
    chk("clear_rd_valid", seen, 0);

    for (int i = 0; i < DEPTH; i++) begin
      rd(i[AW-1:0]);
      chk("cleared_word", data_a, 32'h0);
    end
    idle();

    wr(4'd0, 32'h0000_ABCD, 4'hF);
    wr(4'd1, 32'h0000_EF01, 4'hF);
    wr(4'd2, 32'h0000_2345, 4'hF);
    rd(4'd0);
    chk("lat1_rd0", data_a, 32'h0000_ABCD);
    chk("lat2_rd0_novalid", {31'h0, valid_b}, 32'h0);
    rd(4'd1);
    chk("lat1_rd1", data_a, 32'h0000_EF01);
    chk("lat2_rd0", data_b, 32'h0000_ABCD);
    chk("lat2_v0",  {31'h0, valid_b}, 32'h1);
    rd(4'd2);
    chk("lat1_rd2", data_a, 32'h0000_2345);
    chk("lat2_rd1", data_b, 32'h0000_EF01);
    chk("lat2_v1",  {31'h0, valid_b}, 32'h1);
    idle();
    chk("lat1_done", {31'h0, valid_a}, 32'h0);
    chk("lat2_rd2", data_b, 32'h0000_2345);
    chk("lat2_v2",  {31'h0, valid_b}, 32'h1);
    idle();
    chk("lat2_done", {31'h0, valid_b}, 32'h0);
    chk("lat1_hold", data_a, 32'h0000_2345);

    wr(4'd5, 32'h1122_3344, 4'hF);
    wr(4'd5, 32'hAABB_CCDD, 4'b0101);
    rd(4'd5);
    chk("bytemask_a", data_a, 32'h11BB_33DD);
    chk("bytemask_model", exp_data_a, 32'h11BB_33DD);
    idle();
    chk("bytemask_b", data_b, 32'h11BB_33DD);

    cyc(1'b1, 4'd0, 32'hAAAA_AAAA, 4'hF, 1'b1, 4'd0);
    chk("rdw_old", data_a, 32'h0000_ABCD);
    chk("rdw_old_model", exp_data_a, 32'h0000_ABCD);
    idle();
    chk("rdw_new", data_b, 32'hAAAA_AAAA);
    chk("rdw_new_model", exp_data_b, 32'hAAAA_AAAA);

    cyc(1'b1, 4'd1, 32'hBBBB_BBBB, 4'hF, 1'b1, 4'd2);
    chk("diff_addr_a", data_a, 32'h0000_2345);
    rd(4'd1);
    chk("diff_wr_a", data_a, 32'hBBBB_BBBB);
    chk("diff_addr_b", data_b, 32'h0000_2345);
    idle();
    chk("diff_wr_b", data_b, 32'hBBBB_BBBB);

    rst = 1'b1;
    idle();
    rst = 1'b0;
    repeat (7) idle();
    chk("midclear_busy", {31'h0, busy_a}, 32'h1);
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;
    count_clear(1'b0, n, seen);
    chk("clear3_cycles", n, 16);
    rd(4'd1);
    chk("post_clear_a", data_a, 32'h0);
    idle();
    chk("post_clear_b", data_b, 32'h0);
    idle();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
